// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   - Parity-mode encodings, as driven on parity_mode_i.
//   - Receiver FSM state encoding.
//   - Bit positions inside the per-word error flags {break, parity, framing}.
//   - maj3(): the 2-of-3 vote used to decide each bit.
package uart_pkg;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_NONE  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_BRK_WAIT = 3'd5;

  localparam int ERR_FRM = 0;
  localparam int ERR_PAR = 1;
  localparam int ERR_BRK = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO.
// The head entry is presented on rd_data whenever rd_vld is high; a pop
// happens on rd_vld & rd_rdy. A write into a full FIFO is accepted only if a
// pop happens in the same cycle; otherwise it is dropped and 'drop' pulses.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   wr_en    in   push request
//   wr_data  in   WIDTH  word to push
//   rd_rdy   in   consumer ready
//   rd_vld   out  FIFO non-empty
//   rd_data  out  WIDTH  head word (0 when empty)
//   level    out  occupancy, 0..DEPTH
//   drop     out  push rejected because the FIFO was full with no pop
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_ok;

  assign full   = (count == (PW+1)'(DEPTH));
  assign rd_vld = (count != '0);
  assign pop    = rd_vld & rd_rdy;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a word.
  assign wr_ok  = wr_en & (~full | pop);
  assign drop   = wr_en & full & ~pop;

  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit decisions, false-start
// rejection, parity/framing/break flags per word, sticky overrun and an FWFT
// receive FIFO.
// Optional feature macro: UART_RX_TIMEOUT_EN adds a character timeout that
// fires after TOUT_BITS idle bit-times with data waiting in the FIFO. Without
// it timeout_o is tied low.
// Ports:
//   clk_i          in   clock
//   rst_n_i        in   synchronous active-low reset
//   rx_en_i        in   receiver enable; low discards a partial word
//   parity_mode_i  in   2   00 odd, 01 even, 10 none, 11 space
//   data_bits_i    in   4   data bits per word, 5..DATA_WIDTH (else DATA_WIDTH)
//   baud_div_i     in   BAUDRATE_WIDTH  oversample tick period minus 1
//   rx_i           in   asynchronous serial input
//   rx_rdy_i       in   consumer ready
//   rx_vld_o       out  FIFO head valid
//   rx_data_o      out  DATA_WIDTH  head data, LSB first received
//   rx_err_o       out  3   head flags {break, parity, framing}
//   level_o        out  FIFO occupancy
//   ovr_o          out  sticky overrun
//   ovr_clr_i      in   clears ovr_o (a same-cycle overrun wins)
//   timeout_o      out  character timeout
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | line idle, waiting for a synchronised falling edge
// ST_START    | checking the start bit; a 1 vote is a false start
// ST_DATA     | shifting in data bits, LSB first
// ST_PARITY   | checking the parity bit (skipped when parity is none)
// ST_STOP     | first stop bit; the word is pushed at its mid-bit vote
// ST_BRK_WAIT | break received, waiting for the line to return high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DLY            = 1,
  parameter int DATA_WIDTH     = 8,
  parameter int BAUDRATE_WIDTH = 16,
  parameter int OVS            = 16,
  parameter int DEPTH          = 16,
  parameter int TOUT_BITS      = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       rx_en_i,
  input  logic [1:0]                 parity_mode_i,
  input  logic [3:0]                 data_bits_i,
  input  logic [BAUDRATE_WIDTH-1:0]  baud_div_i,
  input  logic                       rx_i,
  input  logic                       rx_rdy_i,
  output logic                       rx_vld_o,
  output logic [DATA_WIDTH-1:0]      rx_data_o,
  output logic [2:0]                 rx_err_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovr_o,
  input  logic                       ovr_clr_i,
  output logic                       timeout_o
);

  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] OS_S0  = OS_W'(OVS/2 - 1);
  localparam logic [OS_W-1:0] OS_S1  = OS_W'(OVS/2);
  localparam logic [OS_W-1:0] OS_S2  = OS_W'(OVS/2 + 1);
  localparam logic [OS_W-1:0] OS_END = OS_W'(OVS - 1);
  localparam logic [3:0]      DW4    = 4'(DATA_WIDTH);

  // DLY is accepted so existing instantiations keep working; register
  // delays are not modelled. This block only elaborates for a bad setup.
  if (DLY < 0 || TOUT_BITS < 1 || OVS < 8 || (OVS % 2) != 0 ||
      DATA_WIDTH < 5 || DATA_WIDTH > 9 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
  end

  logic                      rx_s1, rx_s2, rx_prev;
  logic [2:0]                state;
  logic [BAUDRATE_WIDTH-1:0] tick_cnt;
  logic                      tick_run, tick;
  logic [OS_W-1:0]           os_cnt;
  logic                      smp0, smp1;
  logic                      bit_val, mid, bit_end, start_det;
  logic [1:0]                par_mode;
  logic [3:0]                nbits, bit_idx;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_err, all_zero, exp_par;
  logic [2:0]                err;
  logic                      push, drop, fifo_vld;
  logic [DATA_WIDTH+2:0]     head;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign start_det = rx_en_i && (state == ST_IDLE) && rx_prev && !rx_s2;

`ifdef UART_RX_TIMEOUT_EN
  // Idle ticks are needed to time the character timeout.
  assign tick_run = rx_en_i && ((state != ST_IDLE) || fifo_vld);
`else
  assign tick_run = rx_en_i && (state != ST_IDLE);
`endif
  assign tick = tick_run && (tick_cnt == '0);

  // Forcing the counter to 0 on the start edge makes the first tick of a
  // frame land on the very next clock, independent of any idle phase.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tick_cnt <= '0;
    end else if (!tick_run || start_det) begin
      tick_cnt <= '0;
    end else if (tick_cnt == '0) begin
      tick_cnt <= baud_div_i;
    end else begin
      tick_cnt <= tick_cnt - BAUDRATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      os_cnt <= '0;
    end else if (!rx_en_i || state == ST_IDLE) begin
      os_cnt <= '0;
    end else if (tick) begin
      os_cnt <= (os_cnt == OS_END) ? '0 : os_cnt + OS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      smp0 <= 1'b0;
      smp1 <= 1'b0;
    end else if (tick) begin
      if (os_cnt == OS_S0) smp0 <= rx_s2;
      if (os_cnt == OS_S1) smp1 <= rx_s2;
    end
  end

  // The third sample is the live synchronised line at the deciding tick.
  assign mid     = tick && (os_cnt == OS_S2);
  assign bit_end = tick && (os_cnt == OS_END);
  assign bit_val = maj3(smp0, smp1, rx_s2);

  always_comb begin
    exp_par = 1'b0;
    case (par_mode)
      PAR_ODD:  exp_par = ~^shreg;
      PAR_EVEN: exp_par = ^shreg;
      default:  exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      par_mode <= '0;
      nbits    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      all_zero <= 1'b0;
    end else if (!rx_en_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            par_mode <= parity_mode_i;
            nbits    <= (data_bits_i < 4'd5 || data_bits_i > DW4) ? DW4 : data_bits_i;
            bit_idx  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            all_zero <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (mid && bit_val) begin
            state <= ST_IDLE;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (bit_idx == 4'(i)) shreg[i] <= bit_val;
            end
            if (bit_val) all_zero <= 1'b0;
          end
          if (bit_end) begin
            if (bit_idx == nbits - 4'd1) begin
              state <= (par_mode == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (mid) begin
            par_err <= (bit_val != exp_par);
            if (bit_val) all_zero <= 1'b0;
          end
          if (bit_end) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at mid-bit so a start bit right after the stop bit is caught.
          if (mid) begin
            state <= (!bit_val && all_zero) ? ST_BRK_WAIT : ST_IDLE;
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err          = '0;
    err[ERR_FRM] = ~bit_val;
    err[ERR_PAR] = par_err;
    err[ERR_BRK] = ~bit_val & all_zero;
  end

  assign push = rx_en_i && (state == ST_STOP) && mid;

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .wr_en   (push),
    .wr_data ({err, shreg}),
    .rd_rdy  (rx_rdy_i),
    .rd_vld  (fifo_vld),
    .rd_data (head),
    .level   (level_o),
    .drop    (drop)
  );

  assign rx_vld_o  = fifo_vld;
  assign rx_data_o = head[DATA_WIDTH-1:0];
  assign rx_err_o  = head[DATA_WIDTH+2:DATA_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovr_o <= 1'b0;
    end else if (drop) begin
      ovr_o <= 1'b1;
    end else if (ovr_clr_i) begin
      ovr_o <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TOUT_BITS + 1);

  logic [OS_W-1:0] to_tick;
  logic [TO_W-1:0] to_bits;
  logic            pop;

  assign pop = fifo_vld & rx_rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      to_tick   <= '0;
      to_bits   <= '0;
      timeout_o <= 1'b0;
    end else if (!rx_en_i || pop || start_det) begin
      to_tick   <= '0;
      to_bits   <= '0;
      timeout_o <= 1'b0;
    end else if (state == ST_IDLE && fifo_vld && !timeout_o && tick) begin
      if (to_tick == OS_END) begin
        to_tick <= '0;
        if (to_bits == TO_W'(TOUT_BITS - 1)) begin
          to_bits   <= '0;
          timeout_o <= 1'b1;
        end else begin
          to_bits <= to_bits + TO_W'(1);
        end
      end else begin
        to_tick <= to_tick + OS_W'(1);
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  localparam int BIT = 64;  // OVS=16 ticks * (baud_div 3 + 1) clocks

  logic        clk;
  logic        rst_n;
  logic        rx_en;
  logic [1:0]  pmode;
  logic [3:0]  dbits;
  logic [15:0] baud;
  logic        rx;
  logic        rdy;
  logic        vld;
  logic [7:0]  data;
  logic [2:0]  err;
  logic [2:0]  level;
  logic        ovr;
  logic        ovr_clr;
  logic        tout;

  int total  = 0;
  int passes = 0;
  logic exp_tout_late;

  uart_rx_os #(
    .DLY(1), .DATA_WIDTH(8), .BAUDRATE_WIDTH(16), .OVS(16), .DEPTH(4), .TOUT_BITS(40)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_en_i(rx_en), .parity_mode_i(pmode),
    .data_bits_i(dbits), .baud_div_i(baud), .rx_i(rx), .rx_rdy_i(rdy),
    .rx_vld_o(vld), .rx_data_o(data), .rx_err_o(err), .level_o(level),
    .ovr_o(ovr), .ovr_clr_i(ovr_clr), .timeout_o(tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic [2:0] e);
    chk({tag, ".vld"},  32'(vld),  32'd1);
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".err"},  32'(err),  32'(e));
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit, data bits LSB first, optional parity; returns at the stop bit start.
  task automatic send_head(input logic [8:0] d, input int nb, input bit has_par, input logic pbit);
    rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      clks(BIT);
    end
    if (has_par) begin
      rx = pbit;
      clks(BIT);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic pbit, input logic sbit);
    send_head(d, nb, has_par, pbit);
    rx = sbit;
    clks(BIT);
    rx = 1'b1;
    clks(8);
  endtask

  task automatic pop_word();
    rdy = 1'b1;
    clks(1);
    rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b1; pmode = 2'b10; dbits = 4'd8; baud = 16'd3;
    rx = 1'b1; rdy = 1'b0; ovr_clr = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    exp_tout_late = 1'b1;
`else
    exp_tout_late = 1'b0;
`endif
    clks(4);
    chk("rst.vld",   32'(vld),   32'd0);
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.ovr",   32'(ovr),   32'd0);
    chk("rst.data",  32'(data),  32'd0);
    chk("rst.err",   32'(err),   32'd0);
    chk("rst.tout",  32'(tout),  32'd0);
    rst_n = 1'b1;
    clks(4);

    // 8N1 0xA5; stop mid-bit decision lands between clocks 615 and 616.
    send_head(9'h0A5, 8, 0, 1'b0);
    rx = 1'b1;
    clks(39);
    chk("a5.vld_early", 32'(vld), 32'd0);
    clks(1);
    chk_word("a5", 8'hA5, 3'b000);
    chk("a5.level", 32'(level), 32'd1);
    clks(24 + 8);
    pop_word();
    chk("a5.level_pop", 32'(level), 32'd0);
    chk("a5.vld_pop",   32'(vld),   32'd0);

    // 7E1 0x35 (four ones): bad parity 1, then good parity 0.
    pmode = 2'b01; dbits = 4'd7;
    send_frame(9'h035, 7, 1, 1'b1, 1'b1);
    chk_word("e7.bad", 8'h35, 3'b010);
    pop_word();
    send_frame(9'h035, 7, 1, 1'b0, 1'b1);
    chk_word("e7.good", 8'h35, 3'b000);
    pop_word();
    // 7O1 0x35 with parity 1 is correct.
    pmode = 2'b00;
    send_frame(9'h035, 7, 1, 1'b1, 1'b1);
    chk_word("o7.good", 8'h35, 3'b000);
    pop_word();
    // Space parity expects 0.
    pmode = 2'b11; dbits = 4'd8;
    send_frame(9'h00F, 8, 1, 1'b1, 1'b1);
    chk_word("s8.bad", 8'h0F, 3'b010);
    pop_word();

    // False start: low for 4 ticks only.
    pmode = 2'b10; dbits = 4'd8;
    rx = 1'b0;
    clks(16);
    rx = 1'b1;
    clks(200);
    chk("fs.level", 32'(level), 32'd0);
    chk("fs.vld",   32'(vld),   32'd0);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b1);
    chk_word("fs.next", 8'h3C, 3'b000);
    chk("fs.next_level", 32'(level), 32'd1);
    pop_word();

    // Out-of-range data_bits falls back to 8; 5-bit words zero-fill the top.
    dbits = 4'd12;
    send_frame(9'h0C3, 8, 0, 1'b0, 1'b1);
    chk_word("db12", 8'hC3, 3'b000);
    pop_word();
    dbits = 4'd5;
    send_frame(9'h013, 5, 0, 1'b0, 1'b1);
    chk_word("db5", 8'h13, 3'b000);
    pop_word();
    dbits = 4'd8;

    // Framing error with non-zero data is not a break.
    send_frame(9'h081, 8, 0, 1'b0, 1'b0);
    chk_word("frm", 8'h81, 3'b001);
    pop_word();

    // Disabling mid-frame discards the partial word.
    rx = 1'b0;
    clks(200);
    rx_en = 1'b0;
    clks(10);
    rx = 1'b1;
    clks(10);
    rx_en = 1'b1;
    clks(700);
    chk("dis.level", 32'(level), 32'd0);

    // Break: 12 bit-times low gives exactly one word.
    rx = 1'b0;
    clks(12 * BIT);
    chk("brk.level", 32'(level), 32'd1);
    chk_word("brk", 8'h00, 3'b101);
    rx = 1'b1;
    clks(200);
    chk("brk.level_idle", 32'(level), 32'd1);
    pop_word();
    chk("brk.level_pop", 32'(level), 32'd0);
    send_frame(9'h05A, 8, 0, 1'b0, 1'b1);
    chk_word("brk.next", 8'h5A, 3'b000);
    chk("brk.next_level", 32'(level), 32'd1);
    pop_word();

    // Overrun with DEPTH=4.
    for (int i = 1; i <= 4; i++) send_frame(9'(8'h11 * i), 8, 0, 1'b0, 1'b1);
    chk("ovr.level4", 32'(level), 32'd4);
    chk("ovr.before", 32'(ovr),   32'd0);
    send_frame(9'h055, 8, 0, 1'b0, 1'b1);
    chk("ovr.level_full", 32'(level), 32'd4);
    chk("ovr.set",        32'(ovr),   32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk_word("ovr.rd", 8'(8'h11 * i), 3'b000);
      pop_word();
    end
    chk("ovr.level_empty", 32'(level), 32'd0);
    chk("ovr.sticky",      32'(ovr),   32'd1);
    ovr_clr = 1'b1;
    clks(1);
    ovr_clr = 1'b0;
    chk("ovr.clr", 32'(ovr), 32'd0);

    // Full FIFO, pop and push in the same clock: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(9'(8'h60 + i), 8, 0, 1'b0, 1'b1);
    chk("fpp.level4", 32'(level), 32'd4);
    send_head(9'h065, 8, 0, 1'b0);
    rx = 1'b1;
    clks(39);
    rdy = 1'b1;
    clks(1);
    rdy = 1'b0;
    chk("fpp.level", 32'(level), 32'd4);
    chk("fpp.ovr",   32'(ovr),   32'd0);
    clks(24 + 8);
    for (int i = 2; i <= 5; i++) begin
      chk_word("fpp.rd", 8'(8'h60 + i), 3'b000);
      pop_word();
    end
    chk("fpp.level_empty", 32'(level), 32'd0);

    // Character timeout: 40 bit-times = 2560 clocks after the word lands.
    send_head(9'h077, 8, 0, 1'b0);
    rx = 1'b1;
    clks(40);
    chk_word("to", 8'h77, 3'b000);
    clks(2540);
    chk("to.early", 32'(tout), 32'd0);
    clks(40);
    chk("to.late", 32'(tout), 32'(exp_tout_late));
    pop_word();
    chk("to.pop",   32'(tout),  32'd0);
    chk("to.level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
